// File: rtl/bram_sp_model.sv
// -----------------------------------------------------------------------------
// bram_sp_model
//   Behavioural model of a single-port synchronous block RAM of arbitrary
//   width and depth. Supports three write modes (write-first, read-first,
//   no-change), an optional output pipeline register, a synchronous output
//   set/reset value and a read-valid strobe. Memory contents start at INIT
//   and are never cleared by reset.
//
// Ports:
//   clock    in   1       rising-edge clock
//   reset_n  in   1       asynchronous active-low reset (outputs only)
//   en       in   1       port enable; low = no read, no write, outputs hold
//   ssr      in   1       synchronous output set/reset to SRVAL (with en)
//   we       in   1       write enable (with en)
//   addr     in   ADDR_W  word address
//   din      in   WIDTH   write data
//   dout     out  WIDTH   read data
//   dvalid   out  1       high when dout carries data from a completed read
// -----------------------------------------------------------------------------
module bram_sp_model #(
    parameter int                 WIDTH      = 9,
    parameter int                 DEPTH      = 2048,
    parameter int                 ADDR_W     = 11,
    parameter int                 WRITE_MODE = 0,
    parameter int                 DO_REG     = 0,
    parameter logic [WIDTH-1:0]   SRVAL      = '0,
    parameter logic [WIDTH-1:0]   INIT       = WIDTH'(9'h15A)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              ssr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              dvalid
);

    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    // Every word starts at INIT so unwritten locations never read as X.
    logic [WIDTH-1:0] mem_q [0:DEPTH-1] = '{default: INIT};

    logic             in_range;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] latch_q, latch_d;
    logic             v1_q, v1_d;

    // DEPTH need not be a power of two, so the top of the address space
    // may fall outside the array.
    assign in_range = ({1'b0, addr} < DEPTH_CMP);
    assign rd_word  = in_range ? mem_q[addr] : '0;

    // Memory array: no reset, so contents survive reset_n.
    always_ff @(posedge clock) begin
        if (en && we && in_range) begin
            mem_q[addr] <= din;
        end
    end

    // Stage 1: read latch and its valid bit.
    always_comb begin
        latch_d = latch_q;
        v1_d    = 1'b0;
        if (en) begin
            if (ssr) begin
                // Output override only; a concurrent write still commits.
                latch_d = SRVAL;
                v1_d    = 1'b0;
            end else if (!in_range) begin
                latch_d = '0;
                v1_d    = 1'b1;
            end else begin
                v1_d = 1'b1;
                if (WRITE_MODE == 1) begin
                    // Non-blocking memory write means rd_word is the old word.
                    latch_d = rd_word;
                end else if (WRITE_MODE == 2) begin
                    if (we) begin
                        v1_d = 1'b0;
                    end else begin
                        latch_d = rd_word;
                    end
                end else begin
                    latch_d = we ? din : rd_word;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= SRVAL;
            v1_q    <= 1'b0;
        end else begin
            latch_q <= latch_d;
            v1_q    <= v1_d;
        end
    end

    // Stage 2: optional output register, loaded on every edge.
    generate
        if (DO_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             dvalid_q, dvalid_d;

            always_comb begin
                dout_d   = latch_q;
                dvalid_d = v1_q;
                if (en && ssr) begin
                    dout_d   = SRVAL;
                    dvalid_d = 1'b0;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q   <= SRVAL;
                    dvalid_q <= 1'b0;
                end else begin
                    dout_q   <= dout_d;
                    dvalid_q <= dvalid_d;
                end
            end

            assign dout   = dout_q;
            assign dvalid = dvalid_q;
        end else begin : g_no_out_reg
            assign dout   = latch_q;
            assign dvalid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sp_model.sv
// -----------------------------------------------------------------------------
// tb_bram_sp_model
//   Directed bench for bram_sp_model. Several instances with different
//   parameter sets share one stimulus stream; each task checks the instance
//   relevant to its scenario against hand-computed values.
//     u_m0  : defaults (WRITE_FIRST, DO_REG 0, SRVAL 0)
//     u_m1  : READ_FIRST
//     u_m2  : NO_CHANGE
//     u_dr  : DO_REG 1, SRVAL 0
//     u_ss  : SRVAL 9'h1FF
//     u_d1k : DEPTH 1000, ADDR_W 10
// -----------------------------------------------------------------------------
module tb_bram_sp_model;

    logic        clock;
    logic        reset_n;
    logic        en, ssr, we;
    logic [10:0] addr;
    logic [8:0]  din;

    logic [8:0] dout_m0, dout_m1, dout_m2, dout_dr, dout_ss, dout_d1k;
    logic       dv_m0, dv_m1, dv_m2, dv_dr, dv_ss, dv_d1k;

    int n_tests = 0;
    int n_fail  = 0;

    bram_sp_model #(.WRITE_MODE(0)) u_m0 (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr), .din(din), .dout(dout_m0), .dvalid(dv_m0));

    bram_sp_model #(.WRITE_MODE(1)) u_m1 (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr), .din(din), .dout(dout_m1), .dvalid(dv_m1));

    bram_sp_model #(.WRITE_MODE(2)) u_m2 (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr), .din(din), .dout(dout_m2), .dvalid(dv_m2));

    bram_sp_model #(.DO_REG(1)) u_dr (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr), .din(din), .dout(dout_dr), .dvalid(dv_dr));

    bram_sp_model #(.SRVAL(9'h1FF)) u_ss (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr), .din(din), .dout(dout_ss), .dvalid(dv_ss));

    bram_sp_model #(.DEPTH(1000), .ADDR_W(10)) u_d1k (
        .clock(clock), .reset_n(reset_n), .en(en), .ssr(ssr), .we(we),
        .addr(addr[9:0]), .din(din), .dout(dout_d1k), .dvalid(dv_d1k));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (dout_m0 !== 9'h000) begin n_fail++; $display("FAIL reset_dout_m0 got %h want %h", dout_m0, 9'h000); end
        n_tests++; if (dv_m0 !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_m0 got %b want 0", dv_m0); end
        n_tests++; if (dout_ss !== 9'h1FF) begin n_fail++; $display("FAIL reset_dout_ss got %h want %h", dout_ss, 9'h1FF); end
        n_tests++; if (dout_dr !== 9'h000) begin n_fail++; $display("FAIL reset_dout_dr got %h want %h", dout_dr, 9'h000); end
        n_tests++; if (dv_dr !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid_dr got %b want 0", dv_dr); end
    endtask

    task automatic test_default_read();
        en = 1'b1; we = 1'b0; addr = 11'd0;
        step();
        n_tests++; if (dout_m0 !== 9'h15A) begin n_fail++; $display("FAIL init_read_dout got %h want %h", dout_m0, 9'h15A); end
        n_tests++; if (dv_m0 !== 1'b1) begin n_fail++; $display("FAIL init_read_dvalid got %b want 1", dv_m0); end
        n_tests++; if (dout_d1k !== 9'h15A) begin n_fail++; $display("FAIL init_read_d1k got %h want %h", dout_d1k, 9'h15A); end
    endtask

    task automatic test_write_modes();
        we = 1'b1; addr = 11'd5; din = 9'h015;
        step();
        we = 1'b0; addr = 11'd0;
        step();
        we = 1'b1; addr = 11'd5; din = 9'h0AA;
        step();
        n_tests++; if (dout_m0 !== 9'h0AA) begin n_fail++; $display("FAIL wf_dout got %h want %h", dout_m0, 9'h0AA); end
        n_tests++; if (dv_m0 !== 1'b1) begin n_fail++; $display("FAIL wf_dvalid got %b want 1", dv_m0); end
        n_tests++; if (dout_m1 !== 9'h015) begin n_fail++; $display("FAIL rf_dout got %h want %h", dout_m1, 9'h015); end
        n_tests++; if (dv_m1 !== 1'b1) begin n_fail++; $display("FAIL rf_dvalid got %b want 1", dv_m1); end
        n_tests++; if (dout_m2 !== 9'h15A) begin n_fail++; $display("FAIL nc_dout got %h want %h", dout_m2, 9'h15A); end
        n_tests++; if (dv_m2 !== 1'b0) begin n_fail++; $display("FAIL nc_dvalid got %b want 0", dv_m2); end
        we = 1'b0;
        step();
        n_tests++; if (dout_m0 !== 9'h0AA) begin n_fail++; $display("FAIL wf_raw got %h want %h", dout_m0, 9'h0AA); end
        n_tests++; if (dout_m1 !== 9'h0AA) begin n_fail++; $display("FAIL rf_raw got %h want %h", dout_m1, 9'h0AA); end
        n_tests++; if (dout_m2 !== 9'h0AA) begin n_fail++; $display("FAIL nc_raw got %h want %h", dout_m2, 9'h0AA); end
        n_tests++; if (dv_m2 !== 1'b1) begin n_fail++; $display("FAIL nc_raw_dvalid got %b want 1", dv_m2); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            we = 1'b1; addr = 11'(i); din = 9'(i);
            step();
        end
        en = 1'b0; we = 1'b0;
        repeat (2) step();
        en = 1'b1; addr = 11'd1;
        step();
        n_tests++; if (dv_dr !== 1'b0) begin n_fail++; $display("FAIL b2b_c1_dvalid got %b want 0", dv_dr); end
        addr = 11'd2;
        step();
        n_tests++; if (dout_dr !== 9'd1 || dv_dr !== 1'b1) begin n_fail++; $display("FAIL b2b_c2 got %h/%b want 001/1", dout_dr, dv_dr); end
        addr = 11'd3;
        step();
        n_tests++; if (dout_dr !== 9'd2 || dv_dr !== 1'b1) begin n_fail++; $display("FAIL b2b_c3 got %h/%b want 002/1", dout_dr, dv_dr); end
        en = 1'b0;
        step();
        n_tests++; if (dout_dr !== 9'd3 || dv_dr !== 1'b1) begin n_fail++; $display("FAIL b2b_c4 got %h/%b want 003/1", dout_dr, dv_dr); end
        step();
        n_tests++; if (dv_dr !== 1'b0) begin n_fail++; $display("FAIL b2b_c5_dvalid got %b want 0", dv_dr); end
    endtask

    task automatic test_ssr();
        en = 1'b1; ssr = 1'b1; we = 1'b1; addr = 11'd7; din = 9'h033;
        step();
        n_tests++; if (dout_ss !== 9'h1FF) begin n_fail++; $display("FAIL ssr_dout got %h want %h", dout_ss, 9'h1FF); end
        n_tests++; if (dv_ss !== 1'b0) begin n_fail++; $display("FAIL ssr_dvalid got %b want 0", dv_ss); end
        n_tests++; if (dout_dr !== 9'h000 || dv_dr !== 1'b0) begin n_fail++; $display("FAIL ssr_doreg got %h/%b want 000/0", dout_dr, dv_dr); end
        ssr = 1'b0; we = 1'b0;
        step();
        n_tests++; if (dout_ss !== 9'h033 || dv_ss !== 1'b1) begin n_fail++; $display("FAIL ssr_write_kept got %h/%b want 033/1", dout_ss, dv_ss); end
        en = 1'b0; ssr = 1'b1;
        step();
        n_tests++; if (dout_ss !== 9'h033) begin n_fail++; $display("FAIL ssr_no_en_dout got %h want %h", dout_ss, 9'h033); end
        n_tests++; if (dv_ss !== 1'b0) begin n_fail++; $display("FAIL ssr_no_en_dvalid got %b want 0", dv_ss); end
        ssr = 1'b0;
    endtask

    task automatic test_out_of_range();
        en = 1'b1; we = 1'b1; addr = 11'd999; din = 9'h099;
        step();
        addr = 11'd1010; din = 9'h077;
        step();
        n_tests++; if (dout_d1k !== 9'h000 || dv_d1k !== 1'b1) begin n_fail++; $display("FAIL oor_write got %h/%b want 000/1", dout_d1k, dv_d1k); end
        we = 1'b0;
        step();
        n_tests++; if (dout_d1k !== 9'h000 || dv_d1k !== 1'b1) begin n_fail++; $display("FAIL oor_read got %h/%b want 000/1", dout_d1k, dv_d1k); end
        n_tests++; if (dout_m0 !== 9'h077) begin n_fail++; $display("FAIL inrange_1010_m0 got %h want %h", dout_m0, 9'h077); end
        addr = 11'd999;
        step();
        n_tests++; if (dout_d1k !== 9'h099 || dv_d1k !== 1'b1) begin n_fail++; $display("FAIL last_word got %h/%b want 099/1", dout_d1k, dv_d1k); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1; we = 1'b0; addr = 11'd2;
        step();
        n_tests++; if (dout_dr !== 9'h099 || dv_dr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stage2 got %h/%b want 099/1", dout_dr, dv_dr); end
        en = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        n_tests++; if (dout_dr !== 9'h000 || dv_dr !== 1'b0) begin n_fail++; $display("FAIL mid_reset_dr got %h/%b want 000/0", dout_dr, dv_dr); end
        n_tests++; if (dv_m0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_m0_dvalid got %b want 0", dv_m0); end
        #2 reset_n = 1'b1;
        step();
        en = 1'b1; addr = 11'd3;
        step();
        n_tests++; if (dv_dr !== 1'b0) begin n_fail++; $display("FAIL post_reset_c1_dvalid got %b want 0", dv_dr); end
        n_tests++; if (dout_m0 !== 9'd3 || dv_m0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_m0 got %h/%b want 003/1", dout_m0, dv_m0); end
        addr = 11'd5;
        step();
        n_tests++; if (dout_dr !== 9'd3 || dv_dr !== 1'b1) begin n_fail++; $display("FAIL post_reset_dr got %h/%b want 003/1", dout_dr, dv_dr); end
        n_tests++; if (dout_m2 !== 9'h0AA) begin n_fail++; $display("FAIL post_reset_addr5 got %h want %h", dout_m2, 9'h0AA); end
        en = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b1;
        en = 1'b0; ssr = 1'b0; we = 1'b0; addr = '0; din = '0;
        #2 reset_n = 1'b0;
        repeat (2) step();
        test_reset();
        reset_n = 1'b1;
        test_default_read();
        test_write_modes();
        test_back_to_back();
        test_ssr();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
